// File: rtl/uart_loader.sv
// Serial program loader: parses load (0x4C) and go (0x47) frames from the UART
// receiver, writes payload bytes into program RAM and starts the CPU on a good go frame.
module uart_loader #(
  parameter int TIMEOUT = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       received,
  output logic [8:0] c_waddr,
  output logic [7:0] dwrite,
  output logic       write_en,
  output logic [8:0] startaddr,
  output logic       go,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_GO   = 8'h47;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CMD  = 2'd1;
  localparam logic [1:0] ERR_SUM  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [3:0] {
    IDLE, L_AHI, L_ALO, L_LEN, L_DATA, L_CSUM, G_AHI, G_ALO, G_CSUM
  } state_t;

  state_t        state_reg, state_next;
  logic [8:0]    addr_reg, addr_next;
  logic [8:0]    rem_reg, rem_next;
  logic [7:0]    sum_reg, sum_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;

  logic [8:0] c_waddr_next;
  logic [7:0] dwrite_next;
  logic       write_en_next;
  logic [8:0] startaddr_next;
  logic       go_next;
  logic       done_next;
  logic [1:0] err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      rem_reg   <= '0;
      sum_reg   <= '0;
      tcnt_reg  <= '0;
      c_waddr   <= '0;
      dwrite    <= '0;
      write_en  <= 1'b0;
      startaddr <= '0;
      go        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rem_reg   <= rem_next;
      sum_reg   <= sum_next;
      tcnt_reg  <= tcnt_next;
      c_waddr   <= c_waddr_next;
      dwrite    <= dwrite_next;
      write_en  <= write_en_next;
      startaddr <= startaddr_next;
      go        <= go_next;
      busy      <= (state_next != IDLE);
      done      <= done_next;
      err       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    rem_next       = rem_reg;
    sum_next       = sum_reg;
    tcnt_next      = tcnt_reg;
    c_waddr_next   = c_waddr;
    dwrite_next    = dwrite;
    write_en_next  = 1'b0;
    startaddr_next = startaddr;
    go_next        = 1'b0;
    done_next      = 1'b0;
    err_next       = err;

    // A received byte always wins over a coinciding timeout expiry.
    if (received) begin
      tcnt_next = '0;
      sum_next  = sum_reg + rx_byte;
      unique case (state_reg)
        IDLE: begin
          sum_next = '0;
          if (rx_byte == CMD_LOAD) begin
            state_next = L_AHI;
            err_next   = ERR_NONE;
          end else if (rx_byte == CMD_GO) begin
            state_next = G_AHI;
            err_next   = ERR_NONE;
          end else begin
            err_next = ERR_CMD;
          end
        end
        L_AHI: begin
          addr_next[8] = rx_byte[0];
          state_next   = L_ALO;
        end
        L_ALO: begin
          addr_next[7:0] = rx_byte;
          state_next     = L_LEN;
        end
        L_LEN: begin
          rem_next   = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
          state_next = L_DATA;
        end
        L_DATA: begin
          write_en_next = 1'b1;
          c_waddr_next  = addr_reg;
          dwrite_next   = rx_byte;
          addr_next     = addr_reg + 9'd1;
          rem_next      = rem_reg - 9'd1;
          if (rem_reg == 9'd1) state_next = L_CSUM;
        end
        L_CSUM: begin
          state_next = IDLE;
          if (rx_byte == sum_reg) done_next = 1'b1;
          else                    err_next  = ERR_SUM;
        end
        G_AHI: begin
          addr_next[8] = rx_byte[0];
          state_next   = G_ALO;
        end
        G_ALO: begin
          addr_next[7:0] = rx_byte;
          state_next     = G_CSUM;
        end
        G_CSUM: begin
          state_next = IDLE;
          if (rx_byte == sum_reg) begin
            startaddr_next = addr_reg;
            go_next        = 1'b1;
            done_next      = 1'b1;
          end else begin
            err_next = ERR_SUM;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE) begin
      if (tcnt_reg == TLAST) begin
        state_next = IDLE;
        err_next   = ERR_TMO;
        tcnt_next  = '0;
      end else begin
        tcnt_next = tcnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised self-checking bench for uart_loader; a frame-level reference model
// predicts the registered outputs cycle by cycle.
module tb_uart_loader;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       received = 1'b0;
  logic [8:0] c_waddr;
  logic [7:0] dwrite;
  logic       write_en;
  logic [8:0] startaddr;
  logic       go;
  logic       busy;
  logic       done;
  logic [1:0] err;

  int vectors = 0;
  int miscompares = 0;

  uart_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
    .c_waddr(c_waddr), .dwrite(dwrite), .write_en(write_en),
    .startaddr(startaddr), .go(go), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is the queue of bytes since the accepted command.
  bit         m_in_frame = 0;
  logic [7:0] m_fb[$];
  int         m_err = 0, m_start = 0, m_silence = 0;
  bit         e_we, e_go, e_done, e_chk_addr;
  int         e_waddr, e_wdata;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input logic [7:0] b);
    int idx, nd, s;
    e_we = 0; e_go = 0; e_done = 0; e_chk_addr = 0;
    if (r) begin
      m_in_frame = 0; m_err = 0; m_start = 0; m_silence = 0;
      e_chk_addr = 1; e_waddr = 0; e_wdata = 0;
    end else if (v) begin
      m_silence = 0;
      if (!m_in_frame) begin
        if (b == 8'h4C || b == 8'h47) begin
          m_in_frame = 1; m_fb = {b}; m_err = 0;
        end else begin
          m_err = 1;
        end
      end else begin
        m_fb.push_back(b);
        idx = m_fb.size() - 1;
        if (m_fb[0] == 8'h47) begin
          if (idx == 3) begin
            m_in_frame = 0;
            if (((m_fb[1] + m_fb[2]) % 256) == b) begin
              m_start = (m_fb[1][0] * 256) + m_fb[2];
              e_go = 1; e_done = 1;
            end else m_err = 2;
          end
        end else if (idx >= 4) begin
          nd = (m_fb[3] == 0) ? 256 : int'(m_fb[3]);
          if (idx <= 3 + nd) begin
            e_we = 1; e_chk_addr = 1;
            e_waddr = ((m_fb[1][0] * 256) + m_fb[2] + idx - 4) % 512;
            e_wdata = b;
          end else begin
            s = 0;
            for (int k = 1; k < idx; k++) s += m_fb[k];
            m_in_frame = 0;
            if ((s % 256) == b) e_done = 1;
            else m_err = 2;
          end
        end
      end
    end else if (m_in_frame) begin
      m_silence++;
      if (m_silence == TMO) begin
        m_in_frame = 0; m_err = 3;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] b);
    rst = r; received = v; rx_byte = b;
    model(r, v, b);
    @(posedge clk); #1;
    check("write_en", write_en, e_we);
    check("go", go, e_go);
    check("done", done, e_done);
    check("err", err, m_err);
    check("busy", busy, m_in_frame);
    check("startaddr", startaddr, m_start);
    if (e_chk_addr) begin
      check("c_waddr", c_waddr, e_waddr);
      check("dwrite", dwrite, e_wdata);
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(0, 1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'($urandom));
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send(bl[i]);
    idle(2);
  endtask

  initial begin
    logic [7:0] fr[$];
    int kind, len, s, gap;
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);

    send_list('{8'h4C, 8'h00, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h39});
    send_list('{8'h4C, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h34});
    send_list('{8'h4C, 8'h00, 8'h20, 8'h01, 8'h55, 8'h00});
    send_list('{8'h47, 8'h01, 8'h05, 8'h06});
    send_list('{8'h47, 8'h00, 8'h07, 8'h00});
    send_list('{8'h58});
    send_list('{8'h4C, 8'h00, 8'h00});
    idle(TMO + 2);
    send_list('{8'h4C, 8'h00, 8'h30, 8'h02, 8'hAA});
    step(1, 0, 8'h00);
    send_list('{8'hBB});

    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 9);
      fr = {};
      if (kind <= 5) begin
        len = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 8);
        fr = {8'h4C, 8'($urandom), 8'($urandom), 8'(len)};
        for (int i = 0; i < ((len == 0) ? 256 : len); i++) fr.push_back(8'($urandom));
      end else if (kind <= 8) begin
        fr = {8'h47, 8'($urandom), 8'($urandom)};
      end else begin
        fr = {8'($urandom_range(0, 8'h46))};
      end
      if (kind <= 8) begin
        s = 0;
        for (int i = 1; i < fr.size(); i++) s += fr[i];
        if ($urandom_range(0, 3) == 0) s ^= $urandom_range(1, 255);
        fr.push_back(8'(s));
      end
      foreach (fr[i]) begin
        send(fr[i]);
        gap = ($urandom_range(0, 15) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 2);
        idle(gap);
        if ($urandom_range(0, 199) == 0) step(1, 0, 8'h00);
      end
    end
    idle(TMO + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
